// File: rtl/uart_result_tx.sv
// Serialises one framed result or status packet as 8N1 UART and pulses done at frame end.
// Frame: 0xA5, payload bytes, XOR checksum of the payload bytes.
//
// state     | meaning
// IDLE      | line high, waiting for an accepted start request
// START_BIT | driving the start bit (0) of the current byte
// DATA_BITS | driving data bits 0..7, LSB first
// STOP_BIT  | driving the stop bit (1); then the next byte or DONE
// DONE      | one-cycle done pulse, busy low, a new request may be accepted
module uart_result_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int NUM_WORDS    = 3,
  parameter int WORD_W       = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          UART_start,
  input  logic [1:0]                    UART_input_sel,
  input  logic [NUM_WORDS*WORD_W-1:0]   result_words,
  input  logic [7:0]                    status_in,
  output logic                          tx,
  output logic                          busy,
  output logic                          UART_transmission_done
);

  localparam int NPAY       = NUM_WORDS * WORD_W / 8;
  localparam int BPW        = WORD_W / 8;
  localparam int NBYTES_MAX = 2 + NPAY;
  localparam int IDXW       = $clog2(NBYTES_MAX + 1);
  localparam int BAUDW      = $clog2(CLKS_PER_BIT);
  localparam logic [BAUDW-1:0] BAUD_LAST = BAUDW'(CLKS_PER_BIT - 1);
  localparam logic [7:0]       SYNC_BYTE = 8'hA5;
  localparam logic [IDXW-1:0]  LAST_RESULT = IDXW'(NPAY + 1);
  localparam logic [IDXW-1:0]  LAST_STATUS = IDXW'(2);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA_BITS = 3'd2,
    STOP_BIT  = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t                r_state;
  logic [BAUDW-1:0]      r_baud;
  logic [2:0]            r_bit_idx;
  logic [IDXW-1:0]       r_byte_idx;
  logic [IDXW-1:0]       r_last_idx;
  logic [7:0]            r_byte;
  logic [7:0]            r_chk;
  logic [NPAY*8-1:0]     r_payload;

  logic                  w_accept;
  logic                  w_sel_status;
  logic [IDXW-1:0]       w_next_idx;
  logic [2:0]            w_bit_next;
  logic [7:0]            w_pay_byte;
  logic [NPAY*8-1:0]     w_result_pay;
  logic [NPAY*8-1:0]     w_status_pay;

  assign w_sel_status = (UART_input_sel == 2'b10);
  assign w_accept     = UART_start && !busy &&
                        ((UART_input_sel == 2'b01) || (UART_input_sel == 2'b10));
  assign w_next_idx   = r_byte_idx + IDXW'(1);
  assign w_bit_next   = r_bit_idx + 3'd1;

  // Payload is stored in transmit order: word 0 first, each word MSB byte first.
  always_comb begin
    w_result_pay = '0;
    for (int w = 0; w < NUM_WORDS; w++) begin
      for (int b = 0; b < BPW; b++) begin
        w_result_pay[(w*BPW + b)*8 +: 8] = result_words[w*WORD_W + (BPW-1-b)*8 +: 8];
      end
    end
    w_status_pay      = '0;
    w_status_pay[7:0] = status_in;
  end

  // Byte index n (1..last-1) carries payload byte n-1.
  always_comb begin
    w_pay_byte = 8'h00;
    for (int p = 0; p < NPAY; p++) begin
      if (w_next_idx == IDXW'(p + 1)) w_pay_byte = r_payload[p*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state                <= IDLE;
      r_baud                 <= '0;
      r_bit_idx              <= '0;
      r_byte_idx             <= '0;
      r_last_idx             <= '0;
      r_byte                 <= '0;
      r_chk                  <= '0;
      r_payload              <= '0;
      tx                     <= 1'b1;
      busy                   <= 1'b0;
      UART_transmission_done <= 1'b0;
    end else begin
      UART_transmission_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_state    <= START_BIT;
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_byte     <= SYNC_BYTE;
            r_chk      <= 8'h00;
            r_payload  <= w_sel_status ? w_status_pay : w_result_pay;
            r_last_idx <= w_sel_status ? LAST_STATUS : LAST_RESULT;
            tx         <= 1'b0;
            busy       <= 1'b1;
          end else begin
            r_state <= IDLE;
            tx      <= 1'b1;
          end
        end
        START_BIT: begin
          if (r_baud == BAUD_LAST) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            tx        <= r_byte[0];
            r_state   <= DATA_BITS;
          end else begin
            r_baud <= r_baud + BAUDW'(1);
          end
        end
        DATA_BITS: begin
          if (r_baud == BAUD_LAST) begin
            r_baud <= '0;
            if (r_bit_idx == 3'd7) begin
              r_bit_idx <= '0;
              tx        <= 1'b1;
              r_state   <= STOP_BIT;
            end else begin
              r_bit_idx <= w_bit_next;
              tx        <= r_byte[w_bit_next];
            end
          end else begin
            r_baud <= r_baud + BAUDW'(1);
          end
        end
        STOP_BIT: begin
          if (r_baud == BAUD_LAST) begin
            r_baud <= '0;
            if (r_byte_idx == r_last_idx) begin
              r_byte_idx             <= '0;
              r_state                <= DONE;
              busy                   <= 1'b0;
              UART_transmission_done <= 1'b1;
            end else begin
              // Checksum folds in each payload byte as it is loaded.
              r_byte_idx <= w_next_idx;
              r_state    <= START_BIT;
              tx         <= 1'b0;
              if (w_next_idx == r_last_idx) begin
                r_byte <= r_chk;
              end else begin
                r_byte <= w_pay_byte;
                r_chk  <= r_chk ^ w_pay_byte;
              end
            end
          end else begin
            r_baud <= r_baud + BAUDW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          tx      <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_result_tx.sv
// Directed bench for uart_result_tx: bit-accurate frame decode, done timing, ignore and reset cases.
module tb_uart_result_tx;

  localparam int C  = 4;
  localparam int NW = 3;
  localparam int WW = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              UART_start;
  logic [1:0]        UART_input_sel;
  logic [NW*WW-1:0]  result_words;
  logic [7:0]        status_in;
  logic              tx;
  logic              busy;
  logic              UART_transmission_done;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_b [8];

  uart_result_tx #(.CLKS_PER_BIT(C), .NUM_WORDS(NW), .WORD_W(WW)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .UART_start             (UART_start),
    .UART_input_sel         (UART_input_sel),
    .result_words           (result_words),
    .status_in              (status_in),
    .tx                     (tx),
    .busy                   (busy),
    .UART_transmission_done (UART_transmission_done)
  );

  always #5 clk = ~clk;

  task automatic set_result_exp();
    exp_b = '{8'hA5, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF, 8'hBF};
  endtask

  task automatic set_status_exp();
    exp_b = '{8'hA5, 8'h3C, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  endtask

  task automatic start_frame(input logic [1:0] sel, input logic [NW*WW-1:0] words,
                             input logic [7:0] st);
    @(negedge clk);
    UART_input_sel = sel;
    result_words   = words;
    status_in      = st;
    UART_start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    UART_start = 1'b0;
  endtask

  // Entered at the first negedge after the accept edge (frame cycle 0).
  task automatic check_frame(input string name, input int nbytes, input bit disturb,
                             input bit chain);
    int total;
    int k, bi, pos;
    logic expbit;
    logic [7:0] dec [8];
    bit bad [8];
    bit bd_err;
    int extra;
    total  = 10 * nbytes * C;
    bd_err = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dec[i] = 8'h00;
      bad[i] = 1'b0;
    end
    for (int t = 0; t < total; t++) begin
      k   = t / C;
      bi  = k / 10;
      pos = k % 10;
      if (pos == 0)      expbit = 1'b0;
      else if (pos == 9) expbit = 1'b1;
      else               expbit = exp_b[bi][pos-1];
      if (tx !== expbit) bad[bi] = 1'b1;
      if (pos >= 1 && pos <= 8 && (t % C) == C/2) dec[bi][pos-1] = tx;
      if (busy !== 1'b1 || UART_transmission_done !== 1'b0) bd_err = 1'b1;
      if (disturb) begin
        if (t == 20) begin
          UART_start     = 1'b1;
          UART_input_sel = 2'b10;
        end
        if (t == 21) UART_start = 1'b0;
        if (t == 30) begin
          UART_start     = 1'b1;
          UART_input_sel = 2'b11;
        end
        if (t == 31) UART_start = 1'b0;
        if (t == 40) begin
          result_words = 48'h5555_0000_FFFF;
          status_in    = 8'h00;
        end
      end
      @(negedge clk);
    end
    for (int i = 0; i < nbytes; i++) begin
      n_cmp++;
      if (bad[i] || dec[i] !== exp_b[i]) begin
        n_bad++;
        $display("FAIL %s byte%0d: got %02h (bit error %0d) expected %02h clean",
                 name, i, dec[i], bad[i], exp_b[i]);
      end
    end
    n_cmp++;
    if (bd_err) begin
      n_bad++;
      $display("FAIL %s busy/done in frame: got a cycle without busy=1 done=0, expected busy=1 done=0 throughout", name);
    end
    n_cmp++;
    if ({UART_transmission_done, busy, tx} !== 3'b101) begin
      n_bad++;
      $display("FAIL %s end at accept+%0d: got done/busy/tx=%b%b%b expected 101",
               name, total, UART_transmission_done, busy, tx);
    end
    if (chain) begin
      UART_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      UART_start = 1'b0;
    end else begin
      @(negedge clk);
      n_cmp++;
      if (UART_transmission_done !== 1'b0) begin
        n_bad++;
        $display("FAIL %s done width: got done=%b one cycle later expected 0", name,
                 UART_transmission_done);
      end
      extra = 0;
      for (int t = 0; t < 40; t++) begin
        @(negedge clk);
        if (UART_transmission_done === 1'b1) extra++;
      end
      n_cmp++;
      if (extra !== 0 || tx !== 1'b1 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL %s after frame: got %0d extra done, tx=%b busy=%b expected 0, 1, 0",
                 name, extra, tx, busy);
      end
    end
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    UART_start     = 1'b0;
    UART_input_sel = 2'b00;
    result_words   = '0;
    status_in      = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (tx !== 1'b1) begin n_bad++; $display("FAIL reset tx: got %b expected 1", tx); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %b expected 0", busy); end
    n_cmp++;
    if (UART_transmission_done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset done: got %b expected 0", UART_transmission_done);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_result_frame();
    set_result_exp();
    start_frame(2'b01, 48'h00FF_ABCD_1234, 8'h00);
    check_frame("result", 8, 1'b0, 1'b0);
  endtask

  task automatic test_status_frame();
    set_status_exp();
    start_frame(2'b10, 48'h0, 8'h3C);
    check_frame("status", 3, 1'b0, 1'b0);
  endtask

  task automatic test_ignore();
    logic [1:0] sels [2];
    sels = '{2'b00, 2'b11};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      UART_input_sel = sels[i];
      UART_start     = 1'b1;
      @(negedge clk);
      UART_start = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || tx !== 1'b1) begin
        n_bad++;
        $display("FAIL ignore sel=%b: got busy=%b tx=%b expected busy=0 tx=1", sels[i], busy, tx);
      end
    end
    set_result_exp();
    start_frame(2'b01, 48'h00FF_ABCD_1234, 8'h00);
    check_frame("ignore_busy", 8, 1'b1, 1'b0);
  endtask

  task automatic test_reset_midframe();
    int dones;
    bit busy_seen;
    start_frame(2'b01, 48'h00FF_ABCD_1234, 8'h00);
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if ({tx, busy, UART_transmission_done} !== 3'b100) begin
      n_bad++;
      $display("FAIL midreset outputs: got tx/busy/done=%b%b%b expected 100", tx, busy,
               UART_transmission_done);
    end
    dones     = 0;
    busy_seen = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (UART_transmission_done === 1'b1) dones++;
      if (busy !== 1'b0 || tx !== 1'b1) busy_seen = 1'b1;
    end
    n_cmp++;
    if (dones !== 0 || busy_seen) begin
      n_bad++;
      $display("FAIL midreset abandon: got %0d done pulses, activity=%b expected 0, 0", dones, busy_seen);
    end
    set_result_exp();
    start_frame(2'b01, 48'h00FF_ABCD_1234, 8'h00);
    check_frame("after_reset", 8, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    set_result_exp();
    start_frame(2'b01, 48'h00FF_ABCD_1234, 8'h00);
    UART_input_sel = 2'b10;
    status_in      = 8'h3C;
    check_frame("b2b_first", 8, 1'b0, 1'b1);
    set_status_exp();
    check_frame("b2b_second", 3, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_result_frame();
    test_status_frame();
    test_ignore();
    test_reset_midframe();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
